// File: rtl/mem_access_arbiter.sv
// Two-port (processor / debug) arbiter and fixed-latency sequencer for a shared single-port data memory.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests; otherwise fixed processor priority.
module mem_access_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_read_orWrite_L,
  input  logic [ADDR_W-1:0] p_address,
  input  logic [DATA_W-1:0] p_dataIn,
  output logic [DATA_W-1:0] p_dataOut,
  output logic              p_mfc,
  input  logic              d_req,
  input  logic              d_read_orWrite_L,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_dataIn,
  output logic [DATA_W-1:0] d_dataOut,
  output logic              d_mfc,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_read_orWrite_L,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  state_t              state_q, state_d;
  logic                op_rd_q, op_rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  logic                pick_debug;
  logic                capture;

  // Winner select; only consulted in IDLE when at least one request is high.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_debug = (p_req && d_req) ? ~owner_q : d_req;
`else
    pick_debug = ~p_req;
`endif
  end

  assign capture = (state_q == WAIT) && (wait_cnt_q == 2'd0);

  always_comb begin
    state_d    = state_q;
    op_rd_d    = op_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (p_req || d_req) begin
          owner_d = pick_debug;
          op_rd_d = pick_debug ? d_read_orWrite_L : p_read_orWrite_L;
          addr_d  = pick_debug ? d_address : p_address;
          wdata_d = pick_debug ? d_dataIn : p_dataIn;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (op_rd_q) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_LAST;
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      op_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= 1'b1;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      op_rd_q    <= op_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // One read-data register per requester; only the owner's is ever loaded.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dout
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (capture && (owner_q == 1'(gi))) begin
        dout_d = mem_dataOut;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end
  end

  assign p_dataOut          = g_dout[0].dout_q;
  assign d_dataOut          = g_dout[1].dout_q;
  assign p_mfc              = (state_q == DONE) && !owner_q;
  assign d_mfc              = (state_q == DONE) && owner_q;
  assign mem_address        = addr_q;
  assign mem_dataIn         = wdata_q;
  assign mem_read_orWrite_L = !((state_q == ACCESS) && !op_rd_q);
  assign owner              = owner_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Two-port arbiter and sequencer for the shared single-port 128 x 32 data memory. It arbitrates between the processor memory port and a debug/loader port (front-panel switch writes and inspection reads). It owns the memory's address, write-data and read/write-low lines. It runs each granted access as a fixed-latency transaction that ends in a one-cycle memory-function-complete (MFC) pulse to the winning requester. The block sits between the Processor/debug logic and the Memory instance and replaces direct processor-to-memory wiring.

## Interface
Parameters:
- ADDR_W, 7, memory word-address width
- DATA_W, 32, data width
- READ_LAT, 1, memory read latency in cycles (legal 1..3)

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- p_req  in  1  processor request, level
- p_read_orWrite_L  in  1  processor op: 1 = read, 0 = write
- p_address  in  ADDR_W  processor word address
- p_dataIn  in  DATA_W  processor write data
- p_dataOut  out  DATA_W  processor read data, registered
- p_mfc  out  1  processor completion pulse
- d_req, d_read_orWrite_L, d_address, d_dataIn, d_dataOut, d_mfc: same as the p_ ports, debug side
- mem_address  out  ADDR_W  to memory
- mem_dataIn  out  DATA_W  write data to memory
- mem_read_orWrite_L  out  1  to memory; 0 only during a write ACCESS cycle
- mem_dataOut  in  DATA_W  read data from memory
- owner  out  1  0 = processor, 1 = debug (last/current grant)
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any req is high, select a winner, latch its op, address and write data into internal registers, set owner, go to ACCESS.
- ACCESS: drive the latched address and data to memory. For a write, mem_read_orWrite_L = 0 for exactly this cycle, then go to DONE. For a read, go to WAIT.
- WAIT: lasts READ_LAT cycles. On the last WAIT edge, capture mem_dataOut into the owner's dataOut register. Then go to DONE.
- DONE: the owner's mfc = 1 for one cycle. Go to IDLE.
- Requester rules:
  - Hold op, address and data stable from req assertion until mfc is seen.
  - Deassert req in the cycle after mfc.
  - A req still high in the IDLE cycle after DONE is treated as a new transaction.
- Requests arriving while busy are held off. They are served from IDLE in arbitration order.
- The non-owner's dataOut is never modified. Both dataOut registers hold their value until that requester's next read.
- All outputs are registered or are decoded from state only; there are no combinational input-to-output paths.
- Reset, including mid-transaction: the next edge forces IDLE and clears the captured op/address/data to 0. Effects:
  - no mfc is issued
  - an in-flight read discards its data
  - mem_read_orWrite_L = 1 from that edge on, so a write in ACCESS is not repeated
- Reset values: p_dataOut = d_dataOut = 0, p_mfc = d_mfc = 0, mem_address = 0, mem_dataIn = 0, mem_read_orWrite_L = 1, owner = 1 (debug, so the processor wins first), busy = 0.
- Outside a write ACCESS cycle, mem_read_orWrite_L = 1. mem_address and mem_dataIn hold their last driven value.

## Timing
- Let cycle 0 be the cycle in which req is high in IDLE.
- Write: ACCESS in cycle 1; mfc in cycle 2; IDLE in cycle 3. Total 3 cycles.
- Read: ACCESS in cycle 1; WAIT in cycles 2..1+READ_LAT; mfc and valid dataOut in cycle 2+READ_LAT. Total 3+READ_LAT cycles.
- Back-to-back: a second pending requester is granted in the IDLE cycle after DONE. There is no bubble beyond IDLE.
- Maximum wait for a request under round-robin: one full foreign transaction plus its own.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous p_req and d_req in IDLE, grant the port that is not the current owner.
  - A single requester is always granted.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, processor always wins.
  - Debug is served only when p_req is low in IDLE.
  - Starvation of debug is permitted.

## Test plan
- Reset, then a processor write with p_address = 7'h05 and p_dataIn = 32'hDEADBEEF → mem_read_orWrite_L = 0 only in cycle 1, mem_address = 5, p_mfc pulses in cycle 2, d_mfc stays 0.
- Processor read of address 5 after that write, READ_LAT = 1 → p_dataOut = 32'hDEADBEEF and p_mfc = 1 in cycle 3; d_dataOut unchanged at 0.
- p_req and d_req raised in the same cycle, held through completion, with ARB_ROUND_ROBIN_EN defined → processor served first, debug granted in the next IDLE, owner sequence 0 then 1. Without the macro, with p_req re-asserted every IDLE → debug never granted.
- Reset asserted during a write's ACCESS cycle → IDLE next edge, exactly one write-low cycle observed, no mfc, busy = 0, all outputs at reset values.
- Debug read with READ_LAT = 3 while p_req rises mid-transaction → d_mfc in cycle 5; processor granted in cycle 6; no overlap of busy transactions.
